// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg
// Shared sizing constants, vector types and the index-to-one-hot helper used
// by the pending encoder slice.
//   N          : number of request lines (power of two, 2..64)
//   W          : index width, $clog2(N)
//   pend_vec_t : N-bit pending / request vector
//   idx_t      : W-bit line index
//   onehot_of  : W-bit index -> N-bit one-hot
package pending_encoder_pkg;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef logic [N-1:0] pend_vec_t;
    typedef logic [W-1:0] idx_t;

    function automatic pend_vec_t onehot_of(input idx_t idx);
        pend_vec_t v;
        v      = {N{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// pending_encoder_if
// Request/flush inputs and the valid/ready index output of the pending encoder.
//   req_in    : request pulses, one bit per line
//   flush     : drop all pending lines
//   out_valid : at least one line pending
//   out_idx   : selected pending line
//   out_ready : consumer takes out_idx this cycle
//   pending   : current pending register
// Modports: master = event source / consumer side, slave = encoder.
interface pending_encoder_if;
    import pending_encoder_pkg::*;

    pend_vec_t req_in;
    logic      flush;
    logic      out_valid;
    idx_t      out_idx;
    logic      out_ready;
    pend_vec_t pending;

    modport master (
        output req_in, flush, out_ready,
        input  out_valid, out_idx, pending
    );

    modport slave (
        input  req_in, flush, out_ready,
        output out_valid, out_idx, pending
    );

endinterface

// File: rtl/pending_encoder_prio_enc.sv
// prio_enc
// Combinational N:W priority encoder; the lowest set bit wins.
//   req : input vector
//   idx : index of the lowest set bit, 0 when none is set
//   any : at least one bit set
module prio_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the last hit (lowest index) sticks.
    always_comb begin
        idx = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? W'(i) : idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/pending_encoder.sv
// pending_encoder
// Collects one-hot/multi-hot request pulses into a pending register and hands
// them out one at a time as binary indices over a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high, clears all state
//   bus   : pending_encoder_if.slave (req_in, flush, out_ready in;
//           out_valid, out_idx, pending out)
// Build option: define ROUND_ROBIN_EN for round-robin selection starting at an
// internal pointer; otherwise fixed lowest-index priority. Ports are identical
// in both builds.
module pending_encoder
    import pending_encoder_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    pending_encoder_if.slave   bus
);

    pend_vec_t pending_r;
    pend_vec_t pending_next_s;
    pend_vec_t search_s;
    pend_vec_t clr_s;
    idx_t      sel_idx_s;
    idx_t      out_idx_s;
    logic      any_s;
    logic      accept_s;

`ifdef ROUND_ROBIN_EN
    idx_t      ptr_r;

    // Rotate right by ptr so the search window starts at ptr and wraps.
    always_comb begin
        search_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            search_s[i] = pending_r[W'(i) + ptr_r];
        end
    end

    // Undo the rotation; the W-bit sum wraps mod N. Force 0 when idle.
    always_comb begin
        if (any_s) begin
            out_idx_s = sel_idx_s + ptr_r;
        end else begin
            out_idx_s = {W{1'b0}};
        end
    end

    // Pointer moves past the line just delivered; flush alone leaves it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= {W{1'b0}};
        end else if (accept_s) begin
            ptr_r <= out_idx_s + W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: search the pending vector directly.
    always_comb begin
        search_s  = pending_r;
        out_idx_s = sel_idx_s;
    end
`endif

    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio (
        .req (search_s),
        .idx (sel_idx_s),
        .any (any_s)
    );

    // Accepted line is cleared; flush drops the rest; new requests always win.
    always_comb begin
        accept_s = any_s & bus.out_ready;
        if (accept_s) begin
            clr_s = onehot_of(out_idx_s);
        end else begin
            clr_s = {N{1'b0}};
        end
        pending_next_s = ((pending_r & ~clr_s) & ~{N{bus.flush}}) | bus.req_in;
    end

    // Pending register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {N{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    assign bus.out_valid = any_s;
    assign bus.out_idx   = out_idx_s;
    assign bus.pending   = pending_r;

endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder
// Scoreboard bench: the stimulus process drives one cycle at a time, derives
// the expected outputs from a set-of-lines reference model and queues them;
// a monitor on the falling edge pops and compares against the DUT.
module tb_pending_encoder;
    import pending_encoder_pkg::*;

    typedef struct {
        bit         valid;
        int         idx;
        bit [N-1:0] pend;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    // Reference model state: which lines are pending, and the search start.
    bit [N-1:0] m_pend;
    int         m_ptr;

    pending_encoder_if bus ();

    pending_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First pending line at or after m_ptr, wrapping; 0 if nothing pending.
    function automatic int m_select();
        int j;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (m_pend[j]) return j;
        end
        return 0;
    endfunction

    // Called just after a rising edge: apply inputs, queue expectation, advance.
    task automatic cycle(input logic [N-1:0] req, input logic fl, input logic rdy);
        exp_t       e;
        bit [N-1:0] nxt;
        bit         acc;
        bus.req_in    = req;
        bus.flush     = fl;
        bus.out_ready = rdy;
        e.valid = (m_pend != '0);
        e.idx   = e.valid ? m_select() : 0;
        e.pend  = m_pend;
        sb_q.push_back(e);
        acc = e.valid && rdy;
        nxt = m_pend;
        if (acc) nxt[e.idx] = 1'b0;
        if (fl) nxt = '0;
        nxt = nxt | req;
`ifdef ROUND_ROBIN_EN
        if (acc) m_ptr = (e.idx + 1) % N;
`endif
        @(posedge clk);
        #1;
        m_pend = nxt;
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("out_valid", int'(bus.out_valid), int'(e.valid));
                chk("out_idx", int'(bus.out_idx), e.idx);
                chk("pending", int'(bus.pending), int'(e.pend));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_pend = '0;
        m_ptr  = 0;
        reset         = 1'b1;
        bus.req_in    = 8'hFF;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held with all requests asserted: nothing may be captured.
        @(negedge clk);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_pending", int'(bus.pending), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(8'hFF, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);      // pending = FF visible here
        cycle(8'h00, 1'b1, 1'b0);      // flush
        cycle(8'h00, 1'b0, 1'b0);

        // 1010_0100 drained with ready held: 2, 5, 7, then idle.
        cycle(8'hA4, 1'b0, 1'b1);
        repeat (4) cycle(8'h00, 1'b0, 1'b1);

        // Clear and re-request of the same bit in one cycle: bit 3 delivered twice.
        cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b1);
        repeat (2) cycle(8'h00, 1'b0, 1'b1);

        // Both ends kept pending: alternates 0/7 with round-robin, else stays 0.
        cycle(8'h81, 1'b0, 1'b0);
        repeat (4) cycle(8'h81, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b0);

        // Flush with new request keeps only the new bit.
        cycle(8'hF0, 1'b0, 1'b0);
        cycle(8'h01, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        // Flush coinciding with an accept.
        cycle(8'hF0, 1'b0, 1'b0);
        cycle(8'h02, 1'b1, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b0);

        // Stall: bit 4 holds steady for 5 cycles, then one accept empties it.
        cycle(8'h10, 1'b0, 1'b0);
        repeat (5) cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset asserted mid-drain clears state without waiting for an edge.
        cycle(8'hFF, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", int'(bus.out_valid), 0);
        chk("async_pending", int'(bus.pending), 0);
        chk("async_idx", int'(bus.out_idx), 0);
        m_pend = '0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle(8'h24, 1'b0, 1'b0);
        repeat (3) cycle(8'h00, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
